// File: rtl/rwl_pulse_seq.sv
// rwl_pulse_seq: read-wordline pulse sequencer with one-entry pending slot.
// Outputs are registered from next-state values so they carry no input-to-output path.
module rwl_pulse_seq #(
  parameter int ADDR_WIDTH     = 3,
  parameter int PULSE_CYCLES   = 2,
  parameter int RECOVER_CYCLES = 1
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       REQ,
  input  logic [ADDR_WIDTH-1:0]      ADDR,
  output logic                       READY,
  output logic [2**ADDR_WIDTH-1:0]   RWL,
  output logic                       BUSY,
  output logic                       DONE
);
  localparam int NW = 2**ADDR_WIDTH;
  localparam int MX = PULSE_CYCLES > RECOVER_CYCLES ? PULSE_CYCLES : RECOVER_CYCLES;
  localparam int CW = $clog2(MX + 1);
  typedef enum logic [1:0] {IDLE, SETUP, PULSE, RECOVER} state_e;
  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] cur_q, cur_d, pend_addr_q, pend_addr_d;
  logic                  pend_q, pend_d, acc, last;
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cur_d       = cur_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    acc         = REQ && READY;
    last        = cnt_q == CW'(1);
    // a request landing on the final recover cycle bypasses the slot and starts directly
    if (acc && state_q != IDLE && !(state_q == RECOVER && last)) begin
      pend_d      = 1'b1;
      pend_addr_d = ADDR;
    end
    case (state_q)
      IDLE: if (acc) begin
        state_d = SETUP;
        cur_d   = ADDR;
      end
      SETUP: begin
        state_d = PULSE;
        cnt_d   = CW'(PULSE_CYCLES);
      end
      PULSE: if (last) begin
        state_d = RECOVER;
        cnt_d   = CW'(RECOVER_CYCLES);
      end else cnt_d = cnt_q - CW'(1);
      RECOVER: if (!last) cnt_d = cnt_q - CW'(1);
      else begin
        cnt_d   = '0;
        state_d = pend_q || acc ? SETUP : IDLE;
        cur_d   = pend_q ? pend_addr_q : acc ? ADDR : cur_q;
        pend_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cur_q       <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      RWL         <= '0;
      READY       <= 1'b1;
      BUSY        <= 1'b0;
      DONE        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cur_q       <= cur_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      RWL         <= state_d == PULSE ? NW'(1) << cur_d : '0;
      READY       <= !pend_d;
      BUSY        <= state_d != IDLE;
      DONE        <= state_d == RECOVER && cnt_d == CW'(1);
    end
  end
endmodule

// File: tb/tb_rwl_pulse_seq.sv
// tb_rwl_pulse_seq: directed checks of rwl_pulse_seq with ADDR_WIDTH=3, P=2, R=1.
module tb_rwl_pulse_seq;
  logic       CLK = 1'b0, RST = 1'b1, REQ = 1'b0;
  logic [2:0] ADDR = '0;
  logic       READY, BUSY, DONE;
  logic [7:0] RWL;
  int n_chk = 0, n_err = 0, cyc = 0;
  int n_done = 0, last_done = -1;
  logic mon_en = 1'b0;
  logic [7:0] any_rwl;
  logic       any_done;
  rwl_pulse_seq #(.ADDR_WIDTH(3), .PULSE_CYCLES(2), .RECOVER_CYCLES(1)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .ADDR(ADDR),
    .READY(READY), .RWL(RWL), .BUSY(BUSY), .DONE(DONE)
  );
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge CLK);
    #1;
  endtask
  always @(negedge CLK) if (mon_en) begin
    check("sweep_onehot", 32'($countones(RWL) <= 1), 1);
    if (RWL != 0) check("sweep_rwl", RWL, 8'(1) << n_done);
    if (DONE) begin
      if (last_done >= 0) check("sweep_gap", cyc - last_done, 4);
      last_done = cyc;
      n_done++;
    end
  end
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
  initial begin
    REQ = 1'b1;
    ADDR = 3'd5;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_rwl", RWL, 0);
      check("rst_ready", READY, 1);
      check("rst_busy", BUSY, 0);
      check("rst_done", DONE, 0);
    end
    REQ = 1'b0;
    RST = 1'b0;
    step();
    step();
    check("rst_no_accept", BUSY, 0);
    REQ = 1'b1;
    ADDR = 3'd3;
    step();
    REQ = 1'b0;
    check("single_c1_rwl", RWL, 0);
    check("single_c1_busy", BUSY, 1);
    step();
    check("single_c2_rwl", RWL, 8'h08);
    step();
    check("single_c3_rwl", RWL, 8'h08);
    step();
    check("single_c4_rwl", RWL, 0);
    check("single_c4_done", DONE, 1);
    step();
    check("single_c5_busy", BUSY, 0);
    check("single_c5_done", DONE, 0);
    REQ = 1'b1;
    ADDR = 3'd0;
    step();
    check("b2b_c1_ready", READY, 1);
    ADDR = 3'd6;
    step();
    for (int c = 2; c <= 13; c++) begin
      check($sformatf("b2b_rwl_c%0d", c), RWL,
            (c == 2 || c == 3) ? 8'h01 : (c == 6 || c == 7) ? 8'h40 : (c == 10 || c == 11) ? 8'h80 : 8'h00);
      check($sformatf("b2b_ready_c%0d", c), READY, (c >= 2 && c <= 4) || (c >= 6 && c <= 8) ? 0 : 1);
      check($sformatf("b2b_done_c%0d", c), DONE, (c == 4 || c == 8 || c == 12) ? 1 : 0);
      check($sformatf("b2b_busy_c%0d", c), BUSY, c <= 12 ? 1 : 0);
      REQ = c <= 5;
      ADDR = 3'd7;
      step();
    end
    REQ = 1'b1;
    ADDR = 3'd4;
    step();
    ADDR = 3'd1;
    step();
    REQ = 1'b0;
    check("rstmid_pulse", RWL, 8'h10);
    #2 RST = 1'b1;
    #1;
    check("rstmid_rwl", RWL, 0);
    check("rstmid_busy", BUSY, 0);
    check("rstmid_ready", READY, 1);
    step();
    RST = 1'b0;
    any_rwl = '0;
    any_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      any_rwl |= RWL;
      any_done |= DONE;
    end
    check("rstmid_no_rwl", any_rwl, 0);
    check("rstmid_no_done", any_done, 0);
    check("rstmid_ready_after", READY, 1);
    mon_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      int guard = 0;
      REQ = 1'b1;
      ADDR = 3'(i);
      while (!READY && guard < 20) begin
        step();
        guard++;
      end
      if (guard >= 20) check("sweep_accept_wait", guard, 0);
      step();
    end
    REQ = 1'b0;
    for (int i = 0; i < 12; i++) step();
    mon_en = 1'b0;
    check("sweep_done_count", n_done, 8);
    check("sweep_idle", BUSY, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/rwl_pulse_seq.md
# rwl_pulse_seq

Read-wordline pulse sequencer sitting directly upstream of the read-wordline buffer stripe. It accepts row-read requests over a valid/ready handshake, decodes the row address to one-hot, and drives a timed, glitch-free wordline pulse on `RWL`, which connects to the stripe's `IN`. A one-entry pending slot lets back-to-back reads issue without idle cycles between operations.

## Interface
- `ADDR_WIDTH`, default 3: row address width; `RWL` width is 2**ADDR_WIDTH.
- `PULSE_CYCLES`, default 2: cycles the selected wordline is held high; legal values are ≥1.
- `RECOVER_CYCLES`, default 1: all-low precharge cycles after each pulse; legal values are ≥1.

- `CLK`  in  1  single clock; all state updates on the rising edge.
- `RST`  in  1  reset, asynchronous, active-high.
- `REQ`  in  1  read request valid.
- `ADDR`  in  ADDR_WIDTH  row to read; sampled when `REQ && READY`.
- `READY`  out  1  request can be accepted this cycle.
- `RWL`  out  2**ADDR_WIDTH  one-hot or all-zero wordline vector, driven to the buffer stripe.
- `BUSY`  out  1  an operation is in SETUP, PULSE or RECOVER.
- `DONE`  out  1  one-cycle strobe in the last RECOVER cycle of each operation.

## Operation
- FSM states are IDLE, SETUP, PULSE and RECOVER. A pending slot holds `pend_valid` and `pend_addr`.
- `READY` = !pend_valid, where pend_valid is a flop.
- A handshake is accepted at a rising edge where `REQ && READY`:
  - In IDLE: the address goes to `cur_addr` and the FSM moves to SETUP.
  - In any other state: the address goes to the pending slot and pend_valid is set.
- SETUP lasts 1 cycle. `RWL` = 0. The FSM then moves to PULSE.
- PULSE lasts PULSE_CYCLES cycles, counted by a down-counter. `RWL` = 1 << cur_addr.
- RECOVER lasts RECOVER_CYCLES cycles. `RWL` = 0, and `DONE` = 1 in the final RECOVER cycle only.
- At the end of RECOVER:
  - If pend_valid: cur_addr ← pend_addr, pend_valid is cleared, and the FSM moves to SETUP.
  - Otherwise: the FSM moves to IDLE.
- `ADDR` is fully decoded, so every value is legal. `RWL` satisfies at most one bit high in every cycle.
- `RWL`, `BUSY`, `DONE` and `READY` are flop outputs with no combinational path from inputs.
- Counter width is clog2(max(PULSE_CYCLES, RECOVER_CYCLES)+1). Counters do not wrap; they reload on each state entry.

## Timing
- Reset values: `RWL`=0, `READY`=1, `BUSY`=0, `DONE`=0, FSM=IDLE, pend_valid=0, counters=0.
- Cycle numbering: let edge 0 be the edge where a request is accepted in IDLE.
  - Cycle 1: SETUP, with `BUSY`=1.
  - Cycles 2..1+P: `RWL` is one-hot.
  - Cycles 2+P..1+P+R: `RWL`=0.
  - Cycle 1+P+R: `DONE`=1.
  - Cycle 2+P+R: the FSM is back in IDLE or has started the next SETUP.
- Operation period is 1+P+R cycles. Back-to-back operations via the pending slot have no IDLE cycle and `BUSY` stays high.
- Latency from accept to the first wordline-high cycle is 2 cycles.
- Pending slot full: `READY`=0 and `REQ` is ignored. The requester must hold `REQ`/`ADDR` stable until accepted.
- Drain and new request in the same cycle: a request is never accepted in the cycle the slot drains, because `READY` is still 0. `READY` rises in the following cycle.
- `REQ` with `READY`=1 in the final RECOVER cycle while the slot is empty: the request enters pending that edge and then drains immediately into SETUP on the same edge. The operations run seamlessly, with no lost request.
- Reset asserted mid-operation forces all outputs to their reset values asynchronously: `RWL` drops the same instant and no `DONE` is issued. A pending request is discarded.
- Reset deassertion is synchronised by the integrator. The block requires `RST` low for one full edge before the first accept.

## Test plan
All scenarios use ADDR_WIDTH=3, P=2, R=1.
- Reset: hold `RST`=1 with `REQ`=1, `ADDR`=5 -> `RWL`=8'b0, `READY`=1, `BUSY`=0, `DONE`=0 throughout. No accept occurs.
- Single read: `ADDR`=3 accepted at edge 0 -> cycle 1 `RWL`=0 with `BUSY`=1; cycles 2–3 `RWL`=8'b0000_1000; cycle 4 `RWL`=0 with `DONE`=1; cycle 5 `BUSY`=0.
- Back-to-back: `ADDR`=0 accepted in IDLE, then `ADDR`=6 accepted in cycle 1 ->
  - `READY`=0 in cycles 2–4.
  - `RWL`=8'b0000_0001 in cycles 2–3, then 8'b0100_0000 in cycles 6–7.
  - `DONE` in cycles 4 and 8. `BUSY` is continuous.
- Backpressure: a third request, `ADDR`=7, is held while pending is full -> not accepted until `READY` rises in cycle 5. Its pulse appears in cycles 10–11.
- Reset mid-pulse: assert `RST` in cycle 2 of a read of `ADDR`=4 with a pending `ADDR`=1 ->
  - `RWL`=0 immediately.
  - After release: `READY`=1, no `DONE`, and no pulse for `ADDR` 1.
- Sweep: issue all 8 addresses back-to-back -> each PULSE has `RWL` == 1<<`ADDR`. At most one `RWL` bit is high in every cycle, and 8 `DONE` strobes appear, each 4 cycles apart.
